simon_decrypt_datapath_serial: RTL and testbench

// Bit-serial SIMON 128/192 decryption engine: the inverse of the bit-serial encryption datapath.

---
 rtl/simon_decrypt_datapath_serial_pkg.sv | 19 +
 rtl/simon_decrypt_datapath_serial_ctrl.sv | 105 ++++++++++
 rtl/simon_decrypt_datapath_serial.sv | 95 +++++++++
 tb/tb_simon_decrypt_datapath_serial.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_decrypt_datapath_serial_pkg.sv
// Shared constants and FSM state type for the bit-serial SIMON 128/192 decryptor.
// Latency: none (declarations only).
// Backpressure: none.
package simon_pkg;

    localparam int N      = 64;
    localparam int ROUNDS = 69;
    localparam int TAP1   = 1;
    localparam int TAP2   = 2;
    localparam int TAP8   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROUND  = 2'd2,
        UNLOAD = 2'd3
    } state_e;

endpackage

// File: rtl/simon_decrypt_datapath_serial_ctrl.sv
// Sequencer for the serial decryptor: FSM, bit/round counters, word-role bit and handshake strobes.
// Latency: LOAD starts the cycle after start; done pulses on the IDLE entry cycle after UNLOAD.
// Backpressure: none; key source and consumers must keep pace every cycle.
module simon_dec_ctrl
    import simon_pkg::*;
#(
    parameter int N      = simon_pkg::N,
    parameter int ROUNDS = simon_pkg::ROUNDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    output state_e     state_o,
    output logic       role_o,
    output logic       load_req_o,
    output logic       key_req_o,
    output logic       out_valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [6:0] key_round_o,
    output logic [5:0] key_bit_o
);

    localparam logic [6:0] LAST_WORD_BIT  = 7'(N - 1);
    localparam logic [6:0] LAST_BLOCK_BIT = 7'(2 * N - 1);
    localparam logic [6:0] LAST_ROUND     = 7'(ROUNDS - 1);

    state_e     state_q, state_d;
    logic [6:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] round_cnt_q, round_cnt_d;
    logic       role_q, role_d;
    logic       done_q, done_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            round_cnt_q <= '0;
            role_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            round_cnt_q <= round_cnt_d;
            role_q      <= role_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + 7'd1;
        round_cnt_d = round_cnt_q;
        role_d      = role_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (start_i) begin
                    state_d = LOAD;
                    role_d  = 1'b0;
                end
            end
            LOAD: begin
                if (bit_cnt_q == LAST_BLOCK_BIT) begin
                    state_d   = ROUND;
                    bit_cnt_d = '0;
                    role_d    = 1'b0;
                end
            end
            ROUND: begin
                // Each round leaves x in the old y register, so the roles swap
                if (bit_cnt_q == LAST_WORD_BIT) begin
                    bit_cnt_d = '0;
                    role_d    = ~role_q;
                    if (round_cnt_q == LAST_ROUND) begin
                        state_d     = UNLOAD;
                        round_cnt_d = '0;
                    end else begin
                        round_cnt_d = round_cnt_q + 7'd1;
                    end
                end
            end
            UNLOAD: begin
                if (bit_cnt_q == LAST_BLOCK_BIT) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o     = state_q;
    assign role_o      = role_q;
    assign load_req_o  = (state_q == LOAD);
    assign key_req_o   = (state_q == ROUND);
    assign out_valid_o = (state_q == UNLOAD);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign key_round_o = key_req_o ? (LAST_ROUND - round_cnt_q) : 7'd0;
    assign key_bit_o   = key_req_o ? bit_cnt_q[5:0] : 6'd0;

endmodule

// File: rtl/simon_decrypt_datapath_serial.sv
// Bit-serial SIMON 128/192 decryption: load 2N ciphertext bits, ROUNDS*N inverse-round cycles, unload 2N bits.
// Latency: first out_valid 2N+ROUNDS*N+1 cycles after start, done pulse 2N cycles later.
// Backpressure: none; key_in must be valid combinationally in every key_req cycle.
module simon_decrypt_datapath_serial
    import simon_pkg::*;
#(
    parameter int N      = simon_pkg::N,
    parameter int ROUNDS = simon_pkg::ROUNDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       data_in,
    input  logic       key_in,
    output logic       load_req,
    output logic       key_req,
    output logic [6:0] key_round,
    output logic [5:0] key_bit,
    output logic       text_out,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    state_e         state;
    logic           role;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   x_cur, y_cur;
    logic [N-1:0]   x_nxt, y_nxt;
    logic           nb;

    simon_dec_ctrl #(
        .N      (N),
        .ROUNDS (ROUNDS)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .state_o     (state),
        .role_o      (role),
        .load_req_o  (load_req),
        .key_req_o   (key_req),
        .out_valid_o (out_valid),
        .busy_o      (busy),
        .done_o      (done),
        .key_round_o (key_round),
        .key_bit_o   (key_bit)
    );

    assign x_cur = role ? b_q : a_q;
    assign y_cur = role ? a_q : b_q;

    // y rotates right, so the top taps hold y'[j-1], y'[j-2], y'[j-8] for bit j
    assign nb = x_cur[0] ^ (y_cur[N-TAP1] & y_cur[N-TAP8]) ^ y_cur[N-TAP2] ^ key_in;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        x_nxt = x_cur;
        y_nxt = y_cur;
        case (state)
            LOAD: begin
                a_d = {data_in, a_q[N-1:1]};
                b_d = {a_q[0], b_q[N-1:1]};
            end
            ROUND: begin
                x_nxt = {nb, x_cur[N-1:1]};
                y_nxt = {y_cur[0], y_cur[N-1:1]};
            end
            UNLOAD: begin
                x_nxt = {1'b0, x_cur[N-1:1]};
                y_nxt = {x_cur[0], y_cur[N-1:1]};
            end
            default: ;
        endcase
        if (state == ROUND || state == UNLOAD) begin
            a_d = role ? y_nxt : x_nxt;
            b_d = role ? x_nxt : y_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign text_out = out_valid & y_cur[0];

endmodule

// File: tb/tb_simon_decrypt_datapath_serial.sv
// Bench for the serial SIMON 128/192 decryptor: three instances (69, 1 and 4 rounds) sharing a key model.
// Expected plaintexts are queued as ciphertext is fed and compared when each 128-bit output completes.
module tb_simon_decrypt_datapath_serial;

    localparam logic [127:0] KAT_CT = 128'hc4ac61effcdc0d4f6c9c8d6e2597b85b;
    localparam logic [127:0] KAT_PT = 128'h206572656874206e6568772065626972;
    localparam int OP_CYCLES = 4 * 64 + 69 * 64 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start_s     [3];
    logic       data_in_s   [3];
    logic       load_req_s  [3];
    logic       key_req_s   [3];
    logic [6:0] key_round_s [3];
    logic [5:0] key_bit_s   [3];
    logic       text_out_s  [3];
    logic       out_valid_s [3];
    logic       busy_s      [3];
    logic       done_s      [3];

    logic [63:0]  rk [69];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q [$];
    int           done_times [$];
    int           kreq_rise [3];
    int           oval_rise [3];
    int           done_cnt  [3];
    int           last_done [3];
    logic [6:0]   kr_first  [3];
    logic [5:0]   kb_first  [3];
    int           ocnt      [3];
    logic [127:0] acc       [3];
    logic         kprev     [3];
    logic         oprev     [3];

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RNDS = (g == 0) ? 69 : ((g == 1) ? 1 : 4);
        localparam bit ZERO_KEY = (g == 1);
        logic key_in_l;

        always_comb begin
            key_in_l = 1'b0;
            if (!ZERO_KEY && key_round_s[g] < 7'd69)
                key_in_l = rk[key_round_s[g]][key_bit_s[g]];
        end

        simon_decrypt_datapath_serial #(
            .N      (64),
            .ROUNDS (RNDS)
        ) u_dut (
            .clk       (clk),
            .reset     (reset_n),
            .start     (start_s[g]),
            .data_in   (data_in_s[g]),
            .key_in    (key_in_l),
            .load_req  (load_req_s[g]),
            .key_req   (key_req_s[g]),
            .key_round (key_round_s[g]),
            .key_bit   (key_bit_s[g]),
            .text_out  (text_out_s[g]),
            .out_valid (out_valid_s[g]),
            .busy      (busy_s[g]),
            .done      (done_s[g])
        );
    end

    function automatic logic [63:0] rol(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [63:0] x, y, t;
        x = pt[127:64];
        y = pt[63:0];
        for (int r = 0; r < nr; r++) begin
            t = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ rk[r];
            y = t;
        end
        return {x, y};
    endfunction

    // Scoreboard and event recorder, sampled on the falling edge
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!reset_n) begin
                ocnt[g]  = 0;
                kprev[g] = 1'b0;
                oprev[g] = 1'b0;
            end else begin
                if (key_req_s[g] && !kprev[g]) begin
                    kreq_rise[g] = cyc;
                    kr_first[g]  = key_round_s[g];
                    kb_first[g]  = key_bit_s[g];
                end
                if (out_valid_s[g] && !oprev[g]) oval_rise[g] = cyc;
                if (out_valid_s[g]) begin
                    acc[g][ocnt[g]] = text_out_s[g];
                    ocnt[g]++;
                    if (ocnt[g] == 128) begin
                        ocnt[g] = 0;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL plaintext_%0d: got %h with nothing expected", g, acc[g]);
                        end else begin
                            logic [127:0] e;
                            e = exp_q.pop_front();
                            if (acc[g] !== e) begin
                                errors++;
                                $display("FAIL plaintext_%0d: got %h expected %h", g, acc[g], e);
                            end
                        end
                    end
                end
                if (done_s[g]) begin
                    done_cnt[g]++;
                    last_done[g] = cyc;
                    if (g == 0) done_times.push_back(cyc);
                end
                kprev[g] = key_req_s[g];
                oprev[g] = out_valid_s[g];
            end
        end
    end

    task automatic feed(input int sel, input logic [127:0] ct, input logic [127:0] pt, output int first_cyc);
        int w;
        w = 0;
        first_cyc = -1;
        @(negedge clk);
        while (!load_req_s[sel] && w < 10000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!load_req_s[sel]) begin
            errors++;
            $display("FAIL load_wait_%0d: load_req=0 after %0d cycles, required 1", sel, w);
            return;
        end
        first_cyc = cyc;
        exp_q.push_back(pt);
        for (int i = 0; i < 128; i++) begin
            data_in_s[sel] = ct[i];
            if (i < 127) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int sel, input int prev, input int bound);
        int w;
        w = 0;
        while (done_cnt[sel] <= prev && w < bound) begin
            @(posedge clk);
            w++;
        end
        checks++;
        if (done_cnt[sel] <= prev) begin
            errors++;
            $display("FAIL done_wait_%0d: done count %0d after %0d cycles, required > %0d", sel, done_cnt[sel], bound, prev);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({load_req_s[g], key_req_s[g], key_round_s[g], key_bit_s[g], text_out_s[g],
                 out_valid_s[g], busy_s[g], done_s[g]} !== 20'd0) begin
                errors++;
                $display("FAIL reset_outputs_%0d: got %b%b_%h_%h_%b%b%b%b required all zero", g,
                         load_req_s[g], key_req_s[g], key_round_s[g], key_bit_s[g],
                         text_out_s[g], out_valid_s[g], busy_s[g], done_s[g]);
            end
        end
    endtask

    task automatic test_kat();
        int t0, fc, pc;
        pc = done_cnt[0];
        @(negedge clk);
        t0 = cyc;
        start_s[0] = 1'b1;
        feed(0, KAT_CT, KAT_PT, fc);
        start_s[0] = 1'b0;
        wait_done(0, pc, 6000);
        checks++;
        if (fc - t0 !== 1) begin
            errors++;
            $display("FAIL kat_load_latency: got %0d required 1", fc - t0);
        end
        checks++;
        if (kreq_rise[0] - t0 !== 129) begin
            errors++;
            $display("FAIL kat_key_latency: got %0d required 129", kreq_rise[0] - t0);
        end
        checks++;
        if (kr_first[0] !== 7'd68 || kb_first[0] !== 6'd0) begin
            errors++;
            $display("FAIL kat_first_key: got round %0d bit %0d required round 68 bit 0", kr_first[0], kb_first[0]);
        end
        checks++;
        if (oval_rise[0] - t0 !== 4545) begin
            errors++;
            $display("FAIL kat_out_latency: got %0d required 4545", oval_rise[0] - t0);
        end
        checks++;
        if (last_done[0] - t0 !== 4673) begin
            errors++;
            $display("FAIL kat_done_latency: got %0d required 4673", last_done[0] - t0);
        end
        checks++;
        if (busy_s[0] !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL kat_idle: busy %b pending %0d required 0 0", busy_s[0], exp_q.size());
        end
    endtask

    task automatic test_single_round();
        int t0, fc, pc;
        pc = done_cnt[1];
        @(negedge clk);
        t0 = cyc;
        start_s[1] = 1'b1;
        feed(1, {64'h0, 64'h1}, {64'h1, 64'h4}, fc);
        start_s[1] = 1'b0;
        wait_done(1, pc, 1000);
        checks++;
        if (last_done[1] - t0 !== 4 * 64 + 64 + 1) begin
            errors++;
            $display("FAIL one_round_done_latency: got %0d required %0d", last_done[1] - t0, 4 * 64 + 64 + 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL one_round_pending: got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] pt;
        int fc, pc;
        for (int n = 0; n < 40; n++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            pc = done_cnt[2];
            @(negedge clk);
            start_s[2] = 1'b1;
            feed(2, encrypt(pt, 4), pt, fc);
            start_s[2] = 1'b0;
            wait_done(2, pc, 1000);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL round_trip_pending: got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_abort();
        int fc, pc, w;
        pc = done_cnt[0];
        @(negedge clk);
        start_s[0] = 1'b1;
        feed(0, KAT_CT, KAT_PT, fc);
        start_s[0] = 1'b0;
        w = 0;
        while (!(key_req_s[0] && key_round_s[0] == 7'd38 && key_bit_s[0] == 6'd17) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!(key_req_s[0] && key_round_s[0] == 7'd38 && key_bit_s[0] == 6'd17)) begin
            errors++;
            $display("FAIL abort_reach: key_round %0d key_bit %0d required 38 17", key_round_s[0], key_bit_s[0]);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({load_req_s[0], key_req_s[0], key_round_s[0], key_bit_s[0], text_out_s[0],
             out_valid_s[0], busy_s[0], done_s[0]} !== 20'd0) begin
            errors++;
            $display("FAIL abort_outputs: busy %b key_req %b key_round %0d key_bit %0d required all zero",
                     busy_s[0], key_req_s[0], key_round_s[0], key_bit_s[0]);
        end
        exp_q.delete();
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt[0] !== pc) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses required %0d", done_cnt[0], pc);
        end
        test_kat();
    endtask

    task automatic test_start_ignored();
        int fc, pc, w;
        pc = done_cnt[0];
        @(negedge clk);
        start_s[0] = 1'b1;
        feed(0, KAT_CT, KAT_PT, fc);
        start_s[0] = 1'b0;
        repeat (300) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        w = 0;
        while (!out_valid_s[0] && w < 6000) begin
            @(negedge clk);
            w++;
        end
        repeat (10) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0, pc, 6000);
        repeat (200) @(negedge clk);
        checks++;
        if (done_cnt[0] !== pc + 1 || busy_s[0] !== 1'b0 || load_req_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: got %0d done busy %b load_req %b required %0d done busy 0 load_req 0",
                     done_cnt[0] - pc, busy_s[0], load_req_s[0], 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt;
        int fc [3];
        int t0, w;
        done_times.delete();
        @(negedge clk);
        t0 = cyc;
        start_s[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            feed(0, encrypt(pt, 69), pt, fc[k]);
        end
        start_s[0] = 1'b0;
        w = 0;
        while (done_times.size() < 3 && w < 20000) begin
            @(posedge clk);
            w++;
        end
        checks++;
        if (done_times.size() != 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d required 3", done_times.size());
        end else begin
            checks++;
            if (done_times[0] - t0 !== OP_CYCLES || done_times[1] - done_times[0] !== OP_CYCLES ||
                done_times[2] - done_times[1] !== OP_CYCLES) begin
                errors++;
                $display("FAIL b2b_done_spacing: got %0d %0d %0d required %0d each",
                         done_times[0] - t0, done_times[1] - done_times[0],
                         done_times[2] - done_times[1], OP_CYCLES);
            end
        end
        checks++;
        if (fc[1] - fc[0] !== OP_CYCLES || fc[2] - fc[1] !== OP_CYCLES) begin
            errors++;
            $display("FAIL b2b_load_spacing: got %0d %0d required %0d", fc[1] - fc[0], fc[2] - fc[1], OP_CYCLES);
        end
        repeat (200) @(negedge clk);
        checks++;
        if (busy_s[0] !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_idle: busy %b pending %0d required 0 0", busy_s[0], exp_q.size());
        end
    endtask

    initial begin
        logic [63:0] z;
        for (int g = 0; g < 3; g++) begin
            start_s[g]   = 1'b0;
            data_in_s[g] = 1'b0;
            done_cnt[g]  = 0;
            ocnt[g]      = 0;
            kreq_rise[g] = 0;
            oval_rise[g] = 0;
            last_done[g] = 0;
        end
        rk[0] = 64'h0706050403020100;
        rk[1] = 64'h0f0e0d0c0b0a0908;
        rk[2] = 64'h1716151413121110;
        z = 64'hfc2ce51207a635db;
        for (int i = 3; i < 69; i++)
            rk[i] = 64'hfffffffffffffffc ^ {63'd0, z[(i - 3) % 62]} ^ rk[i - 3] ^
                    rotr(rk[i - 1], 3) ^ rotr(rk[i - 1], 4);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_kat();
        test_single_round();
        test_round_trip();
        test_reset_abort();
        test_start_ignored();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
